// File: rtl/serial_comparator.sv
// Digit-serial magnitude comparator: walks the operands MSB-first, DIGIT bits per cycle, stopping at the first differing digit.
// Optional feature macro CMP_SIGNED_EN: when defined, signed_mode selects a two's-complement compare.
module serial_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             GT,
  output logic             LT,
  output logic [1:0]       dbg_state
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [WIDTH-1:0] flip_mask;
  logic [DIGIT-1:0] a_dig, b_dig;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
`ifdef CMP_SIGNED_EN
  assign flip_mask = signed_mode ? MSB_MASK : '0;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign flip_mask = '0;
`endif

  // Operands shift left each RUN cycle, so the current digit is always on top.
  assign a_dig = a_q[WIDTH-1 -: DIGIT];
  assign b_dig = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A ^ flip_mask;
          b_d     = B ^ flip_mask;
          idx_d   = '0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        idx_d = idx_q + 1'b1;
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        if (a_dig > b_dig) begin
          gt_d    = 1'b1;
          state_d = S_DONE;
        end else if (a_dig < b_dig) begin
          lt_d    = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign EQ        = eq_q;
  assign GT        = gt_q;
  assign LT        = lt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator (WIDTH=32, DIGIT=2): driver pushes expected {latency, EQ, GT, LT}, monitor checks on done.
module tb_serial_comparator;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        signed_mode;
  logic        busy, done, eq_o, gt_o, lt_o;
  logic [1:0]  dbg_state;

  // Expected word: {latency[5:0], EQ, GT, LT}
  localparam int W = 9;
  logic [W-1:0] exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int start_cyc = 0;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  serial_comparator #(.WIDTH(32), .DIGIT(2)) dut (
    .clock(clock), .reset(reset), .start(start), .A(a_in), .B(b_in),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .EQ(eq_o), .GT(gt_o), .LT(lt_o), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && done) begin
      check("done_busy_low", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, {31'd0, 1'b0} + 32'(exp_q.size()));
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("result_latency", {23'd0, 6'(cyc - start_cyc), eq_o, gt_o, lt_o}, {23'd0, e});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [2:0] res, input int lat);
    @(negedge clock);
    a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
    @(posedge clock); #1;
    start_cyc = cyc;
    exp_q.push_back({6'(lat), res});
    start = 1'b0;
    // Scramble inputs after capture; they must not disturb the result.
    a_in = $urandom; b_in = $urandom; signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic finish_op(input logic [2:0] res);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < 40) begin
      @(negedge clock); #1;
      n++;
    end
    if (n >= 40) begin
      n_cmp++; n_fail++;
      $display("FAIL op_timeout: got no done within 40 cycles expected a done pulse");
      exp_q.delete();
    end
    @(negedge clock);
    check("result_hold", {29'd0, eq_o, gt_o, lt_o}, {29'd0, res});
    check("idle_state", {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input logic [2:0] res, input int lat);
    issue(a, b, sm, res, lat);
    finish_op(res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; signed_mode = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_outputs", {27'd0, busy, done, eq_o, gt_o, lt_o}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_no_start", {30'd0, dbg_state}, 32'd0);

    // Equal operands: all 16 digits examined
    run_op(32'h1234ABCD, 32'h1234ABCD, 1'b0, R_EQ, 16);
    // MSB differs: unsigned and signed views disagree
    run_op(32'h80000000, 32'h00000000, 1'b0, R_GT, 1);
`ifdef CMP_SIGNED_EN
    run_op(32'h80000000, 32'h00000000, 1'b1, R_LT, 1);
    run_op(32'h7FFFFFFF, 32'h80000000, 1'b1, R_GT, 1);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, R_LT, 1);
`else
    run_op(32'h80000000, 32'h00000000, 1'b1, R_GT, 1);
    run_op(32'h7FFFFFFF, 32'h80000000, 1'b1, R_LT, 1);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, R_GT, 1);
`endif
    // Difference only in the last digit, and in digit 5
    run_op(32'h00000005, 32'h00000004, 1'b0, R_GT, 16);
    run_op(32'h00100000, 32'h00200000, 1'b0, R_LT, 6);
    run_op(32'hC0000000, 32'h40000000, 1'b0, R_GT, 1);
    run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, R_EQ, 16);

    // start pulses during RUN and DONE are ignored
    issue(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, R_EQ, 16);
    for (int c = 1; c <= 17; c++) begin
      start = (c == 1 || c == 3 || c == 16);
      a_in = $urandom; b_in = $urandom;
      @(posedge clock); #1;
    end
    start = 1'b0;
    finish_op(R_EQ);
    check("no_requeue_busy", {31'd0, busy}, 32'd0);

    // Reset mid-operation aborts without a result
    issue(32'h55555555, 32'h55555555, 1'b0, R_EQ, 16);
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_outputs", {27'd0, busy, done, eq_o, gt_o, lt_o}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    run_op(32'h00000001, 32'h00000002, 1'b0, R_LT, 16);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 2, bits compared per cycle; SHALL be 1, 2, 4 or 8.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request strobe; SHALL be sampled only while idle.
REQ-006 A  input  WIDTH  first operand; SHALL be captured at accepted start.
REQ-007 B  input  WIDTH  second operand; SHALL be captured at accepted start.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; SHALL be captured at accepted start.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  single-cycle pulse marking a valid result.
REQ-011 EQ  output  1  A == B.
REQ-012 GT  output  1  A > B.
REQ-013 LT  output  1  A < B.

Function
REQ-014 N = WIDTH/DIGIT digits; digit 0 = most significant DIGIT bits.
REQ-015 FSM states IDLE, RUN, DONE; reset state SHALL be IDLE.
REQ-016 IDLE: start=1 at an edge SHALL capture A, B and mode, clear the digit index to 0 and go to RUN; start=0 SHALL stay in IDLE.
REQ-017 Signed capture: with signed compare active, the MSB of both captured operands SHALL be inverted so that the unsigned digit compare yields the signed order.
REQ-018 RUN: each edge SHALL compare one digit, MSB-first, and advance the index by one.
REQ-019 RUN, digits differ: result SHALL be GT or LT per the digit order, and the FSM SHALL go to DONE (early termination).
REQ-020 RUN, digits equal, index < N-1: the FSM SHALL stay in RUN.
REQ-021 RUN, digits equal, index = N-1: EQ SHALL be set and the FSM SHALL go to DONE.
REQ-022 Latency: done SHALL be high in the cycle after the k-th RUN edge, where k (1..N) is the number of digits examined; the worst case is N cycles after the start edge.
REQ-023 DONE: done=1 and busy=0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 Result hold: EQ, GT and LT SHALL be registered, exactly one SHALL be high after done, and they SHALL hold until the next accepted start clears them.
REQ-025 start in RUN or DONE SHALL be ignored; no queuing.
REQ-026 Changes to A, B or signed_mode after capture SHALL not affect the result in progress.
REQ-027 busy SHALL be high in RUN and low in IDLE and DONE.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, clear the index, and set busy, done, EQ, GT and LT to 0, including mid-operation.
REQ-029 After reset deasserts, the first start SHALL be accepted normally; no result from an aborted operation SHALL appear.

Configuration
REQ-030 Macro CMP_SIGNED_EN defined: signed_mode SHALL be honoured per REQ-008 and REQ-017.
REQ-031 Macro CMP_SIGNED_EN undefined: signed_mode SHALL be ignored, the compare SHALL always be unsigned, and the port list SHALL be unchanged.

Verification (WIDTH=32, DIGIT=2, N=16, CMP_SIGNED_EN defined)
REQ-032 A=B=0x1234ABCD, unsigned, start -> done 16 cycles after the start edge, EQ=1, GT=0, LT=0.
REQ-033 A=0x80000000, B=0x00000000, signed_mode=0 -> done 1 cycle after start, GT=1; same operands with signed_mode=1 -> done 1 cycle after start, LT=1.
REQ-034 A=5, B=4, unsigned -> done 16 cycles after start, GT=1; A=0x00100000, B=0x00200000 -> done 6 cycles after start, LT=1.
REQ-035 start pulsed on cycles 1, 3 and 16 during a 16-cycle operation -> only the first is accepted, exactly one done pulse, busy falls with the done cycle.
REQ-036 reset asserted 5 cycles into an equal-operand compare -> busy, done, EQ, GT and LT are 0 immediately; a new start with A=1, B=2 -> LT=1 after 16 cycles.
REQ-037 Build without CMP_SIGNED_EN, A=0xFFFFFFFF, B=1, signed_mode=1 -> GT=1 (unsigned result).
